// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed seven-segment display controller.
// Segment order is {a,b,c,d,e,f,g}, active-low (0 = segment lit).
package disp_pkg;

   localparam int unsigned DEF_NUM_DIGITS  = 8;
   localparam int unsigned DEF_SLOT_CYCLES = 16384;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] GLYPH_0 = 7'b0000001;
   localparam logic [6:0] GLYPH_1 = 7'b1001111;
   localparam logic [6:0] GLYPH_2 = 7'b0010010;
   localparam logic [6:0] GLYPH_3 = 7'b0000110;
   localparam logic [6:0] GLYPH_4 = 7'b1001100;
   localparam logic [6:0] GLYPH_5 = 7'b0100100;
   localparam logic [6:0] GLYPH_6 = 7'b0100000;
   localparam logic [6:0] GLYPH_7 = 7'b0001111;
   localparam logic [6:0] GLYPH_8 = 7'b0000000;
   localparam logic [6:0] GLYPH_9 = 7'b0000100;
   localparam logic [6:0] GLYPH_A = 7'b0001000;
   localparam logic [6:0] GLYPH_B = 7'b1100000;   // lower-case b
   localparam logic [6:0] GLYPH_C = 7'b0110001;
   localparam logic [6:0] GLYPH_D = 7'b1000010;   // lower-case d
   localparam logic [6:0] GLYPH_E = 7'b0110000;
   localparam logic [6:0] GLYPH_F = 7'b0111000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module seg7_decode
   import disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Map each nibble value to its hex glyph
   always_comb begin
      seg = SEG_BLANK;
      unique case (nibble)
         4'h0: seg = GLYPH_0;
         4'h1: seg = GLYPH_1;
         4'h2: seg = GLYPH_2;
         4'h3: seg = GLYPH_3;
         4'h4: seg = GLYPH_4;
         4'h5: seg = GLYPH_5;
         4'h6: seg = GLYPH_6;
         4'h7: seg = GLYPH_7;
         4'h8: seg = GLYPH_8;
         4'h9: seg = GLYPH_9;
         4'hA: seg = GLYPH_A;
         4'hB: seg = GLYPH_B;
         4'hC: seg = GLYPH_C;
         4'hD: seg = GLYPH_D;
         4'hE: seg = GLYPH_E;
         4'hF: seg = GLYPH_F;
      endcase
   end

endmodule

// File: rtl/scan_display_controller.sv
// Time-multiplexed seven-segment display scanner with frame-synchronous
// double buffering, leading-zero blanking and PWM brightness gating.
module scan_display_controller
   import disp_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = DEF_NUM_DIGITS,
   parameter int unsigned SLOT_CYCLES = DEF_SLOT_CYCLES
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    lz_blank,
   input  logic [3:0]              brightness,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic                    frame_done
);

   localparam int unsigned CW   = $clog2(SLOT_CYCLES);
   localparam int unsigned TW   = CW + 1;
   localparam int unsigned IW   = $clog2(NUM_DIGITS);
   localparam int unsigned STEP = SLOT_CYCLES / 16;

   localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   // Scan position
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic          tick;
   logic          boundary;
   logic          wrap_q;

   // Pending (written any time) and display (frame-stable) buffers
   logic [4*NUM_DIGITS-1:0] pend_dig;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic                    pend_valid;
   logic [4*NUM_DIGITS-1:0] disp_dig;
   logic [NUM_DIGITS-1:0]   disp_dp;

   // Per-cycle digit selection
   logic [NUM_DIGITS-1:0][3:0] disp_nib;
   logic [NUM_DIGITS-1:0]      blank;
   logic [NUM_DIGITS-1:0]      sel;
   logic                       zero_run;
   logic [3:0]                 cur_nib;
   logic [6:0]                 cur_glyph;
   logic [TW-1:0]              level;
   logic [TW-1:0]              threshold;
   logic                       lit;

   assign tick     = (cnt == CNT_LAST);
   assign boundary = tick && (idx == IDX_LAST);
   assign disp_nib = disp_dig;
   assign cur_nib  = disp_nib[idx];

   // Slot counter and digit index; wrap_q marks the first cycle of a new frame
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt    <= '0;
         idx    <= '0;
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= boundary;
         if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Double buffer: loads land in pending, display only changes at a frame
   // boundary; a load coinciding with the boundary goes straight to display
   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_dig   <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
         disp_dig   <= '0;
         disp_dp    <= '0;
      end else if (boundary) begin
         pend_valid <= 1'b0;
         if (load) begin
            disp_dig <= digits;
            disp_dp  <= dp_in;
         end else if (pend_valid) begin
            disp_dig <= pend_dig;
            disp_dp  <= pend_dp;
         end
      end else if (load) begin
         pend_dig   <= digits;
         pend_dp    <= dp_in;
         pend_valid <= 1'b1;
      end
   end

   // Leading-zero mask: walk down from the top digit while nibbles stay zero;
   // digit 0 is never part of the mask
   always_comb begin
      blank    = '0;
      zero_run = lz_blank;
      for (int unsigned i = 0; i < NUM_DIGITS - 1; i++) begin
         zero_run = zero_run & (disp_nib[NUM_DIGITS-1-i] == 4'h0);
         blank[NUM_DIGITS-1-i] = zero_run;
      end
   end

   // PWM gate: digit lit for the first (brightness+1)/16 of its slot
   always_comb begin
      level     = TW'(brightness) + TW'(1);
      threshold = level * TW'(STEP);
      lit       = ({1'b0, cnt} < threshold);
   end

   // One-hot select of the active digit
   always_comb begin
      sel      = '0;
      sel[idx] = 1'b1;
   end

   seg7_decode u_decode (
      .nibble (cur_nib),
      .seg    (cur_glyph)
   );

   // Registered outputs, one cycle behind the scan position
   always_ff @(posedge clk) begin
      if (!reset) begin
         anode      <= '1;
         seg        <= SEG_BLANK;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= wrap_q;
         if (lit) begin
            anode <= ~sel;
            seg   <= blank[idx] ? SEG_BLANK : cur_glyph;
            dp    <= ~disp_dp[idx];
         end else begin
            anode <= '1;
            seg   <= SEG_BLANK;
            dp    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_scan_display_controller.sv
// Self-checking bench for scan_display_controller with 4 digits, 32-cycle slots.
module tb_scan_display_controller;

   localparam int ND    = 4;
   localparam int SC    = 32;
   localparam int FRAME = ND * SC;

   logic        clk;
   logic        reset;
   logic [15:0] digits;
   logic [3:0]  dp_in;
   logic        load;
   logic        lz_blank;
   logic [3:0]  brightness;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  anode;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   scan_display_controller #(
      .NUM_DIGITS  (ND),
      .SLOT_CYCLES (SC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .digits     (digits),
      .dp_in      (dp_in),
      .load       (load),
      .lz_blank   (lz_blank),
      .brightness (brightness),
      .seg        (seg),
      .dp         (dp),
      .anode      (anode),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Active-high abcdefg glyphs for hex 0..F
   logic [6:0] hi_glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int unsigned n;            // clock edges since reset release
   logic [15:0] m_disp, m_pend;
   logic [3:0]  m_ddp, m_pdp;
   bit          m_pv;
   logic [3:0]  e_anode;
   logic [6:0]  e_seg;
   logic        e_dp, e_fd;
   bit          chk_en = 0;

   initial forever begin
      int pos, dig, hi;
      @(posedge clk);
      if (!reset) begin
         n = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pv = 0;
         e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      end else begin
         pos  = int'(n % SC);
         dig  = int'((n / SC) % ND);
         e_fd = (n != 0) && (n % FRAME == 0);
         if (pos < (int'(brightness) + 1) * SC / 16) begin
            hi = 0;
            for (int k = 0; k < ND; k++)
               if (m_disp[k*4 +: 4] != 4'h0) hi = k;
            e_anode      = 4'hF;
            e_anode[dig] = 1'b0;
            e_seg = (lz_blank && dig > hi) ? 7'h7F : ~hi_glyph[m_disp[dig*4 +: 4]];
            e_dp  = ~m_ddp[dig];
         end else begin
            e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
         end
         if (n % FRAME == FRAME - 1) begin
            if (load) begin m_disp = digits; m_ddp = dp_in; end
            else if (m_pv) begin m_disp = m_pend; m_ddp = m_pdp; end
            m_pv = 0;
         end else if (load) begin
            m_pend = digits; m_pdp = dp_in; m_pv = 1;
         end
         n++;
      end
      chk_en = 1;
   end

   // Cycle-by-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("anode", 32'(anode), 32'(e_anode));
         check("seg", 32'(seg), 32'(e_seg));
         check("dp", 32'(dp), 32'(e_dp));
         check("frame_done", 32'(frame_done), 32'(e_fd));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_digit(input int d);
      logic [3:0] want;
      bit ok;
      want = 4'hF;
      want[d] = 1'b0;
      ok = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (anode == want) begin ok = 1; break; end
      end
      if (!ok) check("wait_digit_timeout", 32'(anode), 32'(want));
   endtask

   task automatic show(input string name, input int d, input logic [6:0] s, input logic p);
      wait_digit(d);
      check(name, 32'(seg), 32'(s));
      check({name, "_dp"}, 32'(dp), 32'(p));
   endtask

   task automatic wait_fd();
      bit ok;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (frame_done) begin ok = 1; break; end
      end
      if (!ok) check("frame_done_timeout", 32'(frame_done), 32'd1);
   endtask

   task automatic pulse_load(input logic [15:0] v, input logic [3:0] p);
      digits = v; dp_in = p; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cnt_on, cnt_bad, period;
      reset = 1'b0; load = 1'b0; digits = '0; dp_in = '0; lz_blank = 1'b0; brightness = 4'd15;
      repeat (3) @(negedge clk);
      check("rst_anode", 32'(anode), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp", 32'(dp), 32'd1);
      check("rst_fd", 32'(frame_done), 32'd0);

      reset = 1'b1;
      @(negedge clk);
      check("first_anode", 32'(anode), 32'b1110);
      check("first_seg", 32'(seg), 32'b0000001);

      // Mid-frame load only shows after the next boundary
      repeat (38) @(negedge clk);
      pulse_load(16'h12AF, 4'b0010);
      show("pre_boundary_d2", 2, 7'b0000001, 1'b1);
      show("pre_boundary_d3", 3, 7'b0000001, 1'b1);
      show("glyph_F", 0, 7'b0111000, 1'b1);
      show("glyph_A", 1, 7'b0001000, 1'b0);
      show("glyph_2", 2, 7'b0010010, 1'b1);
      show("glyph_1", 3, 7'b1001111, 1'b1);

      // Frame period
      wait_fd();
      period = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         period++;
         if (frame_done) break;
      end
      check("frame_period", 32'(period), 32'd128);

      // Brightness 3: 8 of every 32 cycles lit
      brightness = 4'd3;
      repeat (40) @(negedge clk);
      cnt_on = 0; cnt_bad = 0;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (anode != 4'hF) cnt_on++;
         else if (seg != 7'h7F || dp != 1'b1) cnt_bad++;
      end
      check("dim_on_cycles", 32'(cnt_on), 32'd32);
      check("dim_off_lit", 32'(cnt_bad), 32'd0);
      brightness = 4'd15;

      // Leading-zero blanking; dp survives on a blanked digit
      lz_blank = 1'b1;
      pulse_load(16'h0050, 4'b0100);
      repeat (130) @(negedge clk);
      show("lz_d3", 3, 7'b1111111, 1'b1);
      show("lz_d2", 2, 7'b1111111, 1'b0);
      show("lz_d1", 1, 7'b0100100, 1'b1);
      show("lz_d0", 0, 7'b0000001, 1'b1);
      pulse_load(16'h0000, 4'b0000);
      repeat (130) @(negedge clk);
      show("lz0_d3", 3, 7'b1111111, 1'b1);
      show("lz0_d1", 1, 7'b1111111, 1'b1);
      show("lz0_d0", 0, 7'b0000001, 1'b1);
      lz_blank = 1'b0;

      // Later load in the same frame overwrites pending
      pulse_load(16'h1111, 4'b0000);
      repeat (4) @(negedge clk);
      pulse_load(16'h2222, 4'b0000);
      repeat (130) @(negedge clk);
      show("overwrite_d2", 2, 7'b0010010, 1'b1);

      // Load on the boundary cycle bypasses pending
      wait_fd();
      repeat (126) @(negedge clk);
      digits = 16'h9999; dp_in = 4'b0000; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("bypass_last_old", 32'(seg), 32'b0010010);
      @(negedge clk);
      check("bypass_fd", 32'(frame_done), 32'd1);
      check("bypass_anode", 32'(anode), 32'b1110);
      check("bypass_glyph9", 32'(seg), 32'b0000100);

      // Reset mid-frame discards pending data
      repeat (50) @(negedge clk);
      pulse_load(16'h7777, 4'b1111);
      repeat (10) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_anode", 32'(anode), 32'hF);
      check("midrst_seg", 32'(seg), 32'h7F);
      check("midrst_dp", 32'(dp), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("rel_anode", 32'(anode), 32'b1110);
      check("rel_seg", 32'(seg), 32'b0000001);
      repeat (200) @(negedge clk);
      show("after_rst_d0", 0, 7'b0000001, 1'b1);
      show("after_rst_d3", 3, 7'b0000001, 1'b1);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/scan_display_controller.md
SCAN_DISPLAY_CONTROLLER -- requirements
Module: scan_display_controller

Interface
REQ-001 Parameter NUM_DIGITS, 8, number of multiplexed digits (2..16).
REQ-002 Parameter SLOT_CYCLES, 16384, clocks per digit slot; SHALL be a multiple of 16.
REQ-003 Port clk  input  1  system clock; single clock domain.
REQ-004 Port reset  input  1  synchronous, active-low reset.
REQ-005 Port digits  input  4*NUM_DIGITS  hex nibbles; nibble k = digit k, digit 0 = rightmost.
REQ-006 Port dp_in  input  NUM_DIGITS  decimal-point request per digit.
REQ-007 Port load  input  1  one-cycle strobe capturing digits/dp_in into the pending buffer.
REQ-008 Port lz_blank  input  1  leading-zero suppression enable.
REQ-009 Port brightness  input  4  duty level 0..15.
REQ-010 Port seg  output  7  segments {a,b,c,d,e,f,g}, active-low.
REQ-011 Port dp  output  1  decimal point, active-low.
REQ-012 Port anode  output  NUM_DIGITS  digit enables, active-low, at most one low.
REQ-013 Port frame_done  output  1  one-cycle pulse when digit index wraps NUM_DIGITS-1 -> 0.

Function
REQ-014 Slot counter SHALL count 0..SLOT_CYCLES-1 and wrap; wrap cycle = tick.
REQ-015 On tick, digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0 (frame boundary).
REQ-016 Active digit SHALL be on only while slot counter < (brightness+1)*SLOT_CYCLES/16; otherwise all anodes high and seg/dp high.
REQ-017 load SHALL write digits/dp_in into pending registers and set pending_valid; a later load before the boundary overwrites.
REQ-018 At frame boundary with pending_valid=1, display registers SHALL take pending contents and pending_valid SHALL clear.
REQ-019 load asserted on the frame-boundary cycle SHALL bypass pending and take effect in the display registers at that boundary.
REQ-020 Display registers SHALL change only at frame boundaries (no mid-frame tearing).
REQ-021 With lz_blank=1, digits from NUM_DIGITS-1 downward whose display nibble is 0 SHALL be blanked up to the first nonzero digit; digit 0 never blanked; dp unaffected by blanking.
REQ-022 Blanked digit: anode still scanned low, seg = 7'b1111111.
REQ-023 Decode SHALL map 0-F to standard hex glyphs (b, d lower case).
REQ-024 seg, dp, anode SHALL be registered: values reflect index/counter state of the previous cycle (latency 1).
REQ-025 frame_done SHALL pulse high for exactly one cycle, aligned with the registered outputs of the first digit-0 cycle.
REQ-026 brightness changes SHALL apply from the next clock; no glitch beyond one slot.

Reset
REQ-027 While reset=0 at a rising clk edge: slot counter 0, index 0, pending and display registers 0, pending_valid 0.
REQ-028 Reset outputs: anode all 1, seg 7'b1111111, dp 1, frame_done 0.
REQ-029 Reset mid-frame SHALL discard pending data; first slot after release is digit 0, counter 0.

Structure
REQ-030 Segment glyph constants, SLOT_CYCLES default, and NUM_DIGITS default SHALL live in shared package disp_pkg.
REQ-031 Nibble-to-glyph decode SHALL be sub-module seg7_decode (combinational, 4-bit in, 7-bit active-low out).
REQ-032 Counters, buffering, blanking, PWM gate in the top module; no other sub-modules.

Verification (NUM_DIGITS=4, SLOT_CYCLES=32)
REQ-033 Reset release, brightness=15 -> anode 1110,1101,1011,0111 each 32 cycles; frame_done every 128 cycles.
REQ-034 load digits=16'h12AF at cycle 40 -> display unchanged until cycle 128 boundary, then seg glyphs F,A,2,1 on digits 0..3.
REQ-035 brightness=3 -> each anode low 8 of 32 cycles, high 24; seg=1111111 during off window.
REQ-036 lz_blank=1, digits=16'h0050 -> digits 3,2 seg=1111111, digit 1 shows 5, digit 0 shows 0; digits=16'h0000 -> only digit 0 lit with 0.
REQ-037 load on boundary cycle with 16'h9999 -> 9s shown from that frame; reset low mid-frame after load 16'h7777 -> outputs blank, display 0000.
